hyperbus_axi_arbiter: RTL and testbench

//  Shares the single wide AXI slave port of the HyperBus subsystem between two AXI masters.

---
 rtl/hyperbus_arb_pkg.sv | 30 +++
 rtl/hyperbus_rr_arb4.sv | 27 ++
 rtl/hyperbus_axi_arbiter.sv | 150 +++++++++++++++
 tb/tb_hyperbus_axi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_arb_pkg.sv
// Shared types and constants for the two-master HyperBus AXI arbiter.
// Channel payloads travel as packed vectors; the last flag of W and R sits in bit 0.
package hyperbus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR_FWD = 3'd1,
        R_DATA = 3'd2,
        AW_FWD = 3'd3,
        W_DATA = 3'd4,
        B_RESP = 3'd5
    } arb_state_e;

    localparam int NUM_SRC = 4;

    // Bit 1 of a source index selects the port, bit 0 selects write (1) or read (0).
    localparam logic [1:0] SRC_S0_AR = 2'd0;
    localparam logic [1:0] SRC_S0_AW = 2'd1;
    localparam logic [1:0] SRC_S1_AR = 2'd2;
    localparam logic [1:0] SRC_S1_AW = 2'd3;

    // len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4)
    localparam int AX_CTRL_BITS = 29;
    localparam int RESP_BITS    = 2;

    function automatic logic [1:0] src_next(input logic [1:0] src);
        return src + 2'd1;
    endfunction

endpackage

// File: rtl/hyperbus_rr_arb4.sv
// Combinational four-way round-robin pick: first requester at or after ptr wins.
module hyperbus_rr_arb4
    import hyperbus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic               grant_valid,
    output logic [1:0]         grant_idx
);

    // Scan ptr, ptr+1, ... with wrap; keep the first hit.
    always_comb begin
        logic [1:0] cand_s;
        logic       hit_s;
        cand_s      = ptr;
        hit_s       = 1'b0;
        grant_valid = 1'b0;
        grant_idx   = ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s      = ptr + 2'(i);
            hit_s       = req[cand_s] & ~grant_valid;
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | req[cand_s];
        end
    end

endmodule

// File: rtl/hyperbus_axi_arbiter.sv
// Shares the HyperBus AXI slave port between two masters, one whole AR+R or
// AW+W+B transaction at a time, round-robin over {s1.aw, s1.ar, s0.aw, s0.ar}.
module hyperbus_axi_arbiter
    import hyperbus_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 10,
    localparam int AX_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AX_CTRL_BITS + AXI_USER_WIDTH,
    localparam int W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + AXI_USER_WIDTH + 1,
    localparam int R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + RESP_BITS + AXI_USER_WIDTH + 1,
    localparam int B_W  = AXI_ID_WIDTH + RESP_BITS + AXI_USER_WIDTH
)(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AX_W-1:0] slv0_ar_chan,
    input  logic            slv0_ar_valid,
    output logic            slv0_ar_ready,
    input  logic [AX_W-1:0] slv0_aw_chan,
    input  logic            slv0_aw_valid,
    output logic            slv0_aw_ready,
    input  logic [W_W-1:0]  slv0_w_chan,
    input  logic            slv0_w_valid,
    output logic            slv0_w_ready,
    output logic [R_W-1:0]  slv0_r_chan,
    output logic            slv0_r_valid,
    input  logic            slv0_r_ready,
    output logic [B_W-1:0]  slv0_b_chan,
    output logic            slv0_b_valid,
    input  logic            slv0_b_ready,
    input  logic [AX_W-1:0] slv1_ar_chan,
    input  logic            slv1_ar_valid,
    output logic            slv1_ar_ready,
    input  logic [AX_W-1:0] slv1_aw_chan,
    input  logic            slv1_aw_valid,
    output logic            slv1_aw_ready,
    input  logic [W_W-1:0]  slv1_w_chan,
    input  logic            slv1_w_valid,
    output logic            slv1_w_ready,
    output logic [R_W-1:0]  slv1_r_chan,
    output logic            slv1_r_valid,
    input  logic            slv1_r_ready,
    output logic [B_W-1:0]  slv1_b_chan,
    output logic            slv1_b_valid,
    input  logic            slv1_b_ready,
    output logic [AX_W-1:0] mst_ar_chan,
    output logic            mst_ar_valid,
    input  logic            mst_ar_ready,
    output logic [AX_W-1:0] mst_aw_chan,
    output logic            mst_aw_valid,
    input  logic            mst_aw_ready,
    output logic [W_W-1:0]  mst_w_chan,
    output logic            mst_w_valid,
    input  logic            mst_w_ready,
    input  logic [R_W-1:0]  mst_r_chan,
    input  logic            mst_r_valid,
    output logic            mst_r_ready,
    input  logic [B_W-1:0]  mst_b_chan,
    input  logic            mst_b_valid,
    output logic            mst_b_ready
);

    arb_state_e state_r, state_s;
    logic       owner_r, owner_s;
    logic [1:0] ptr_r, ptr_s;
    logic       grant_valid_s;
    logic [1:0] grant_idx_s;
    logic       st_ar_s, st_r_s, st_aw_s, st_w_s, st_b_s;

    hyperbus_rr_arb4 u_rr_arb (
        .req         ({slv1_aw_valid, slv1_ar_valid, slv0_aw_valid, slv0_ar_valid}),
        .ptr         (ptr_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            ptr_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
        end
    end

    // Transaction sequencing; a burst ends only on the last-beat flag.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    owner_s = (grant_idx_s == SRC_S1_AR) || (grant_idx_s == SRC_S1_AW);
                    ptr_s   = src_next(grant_idx_s);
                    state_s = ((grant_idx_s == SRC_S0_AW) || (grant_idx_s == SRC_S1_AW))
                              ? AW_FWD : AR_FWD;
                end else begin
                    state_s = IDLE;
                end
            end
            AR_FWD:  state_s = (mst_ar_valid && mst_ar_ready) ? R_DATA : AR_FWD;
            R_DATA:  state_s = (mst_r_valid && mst_r_ready && mst_r_chan[0]) ? IDLE : R_DATA;
            AW_FWD:  state_s = (mst_aw_valid && mst_aw_ready) ? W_DATA : AW_FWD;
            W_DATA:  state_s = (mst_w_valid && mst_w_ready && mst_w_chan[0]) ? B_RESP : W_DATA;
            B_RESP:  state_s = (mst_b_valid && mst_b_ready) ? IDLE : B_RESP;
            default: state_s = IDLE;
        endcase
    end

    assign st_ar_s = (state_r == AR_FWD);
    assign st_r_s  = (state_r == R_DATA);
    assign st_aw_s = (state_r == AW_FWD);
    assign st_w_s  = (state_r == W_DATA);
    assign st_b_s  = (state_r == B_RESP);

    // Payloads are muxed freely; only valid/ready are qualified by state and owner.
    assign mst_ar_chan   = owner_r ? slv1_ar_chan : slv0_ar_chan;
    assign mst_ar_valid  = st_ar_s & (owner_r ? slv1_ar_valid : slv0_ar_valid);
    assign slv0_ar_ready = st_ar_s & ~owner_r & mst_ar_ready;
    assign slv1_ar_ready = st_ar_s &  owner_r & mst_ar_ready;

    assign mst_aw_chan   = owner_r ? slv1_aw_chan : slv0_aw_chan;
    assign mst_aw_valid  = st_aw_s & (owner_r ? slv1_aw_valid : slv0_aw_valid);
    assign slv0_aw_ready = st_aw_s & ~owner_r & mst_aw_ready;
    assign slv1_aw_ready = st_aw_s &  owner_r & mst_aw_ready;

    assign mst_w_chan    = owner_r ? slv1_w_chan : slv0_w_chan;
    assign mst_w_valid   = st_w_s & (owner_r ? slv1_w_valid : slv0_w_valid);
    assign slv0_w_ready  = st_w_s & ~owner_r & mst_w_ready;
    assign slv1_w_ready  = st_w_s &  owner_r & mst_w_ready;

    assign slv0_r_chan   = mst_r_chan;
    assign slv1_r_chan   = mst_r_chan;
    assign mst_r_ready   = st_r_s & (owner_r ? slv1_r_ready : slv0_r_ready);
    assign slv0_r_valid  = st_r_s & ~owner_r & mst_r_valid;
    assign slv1_r_valid  = st_r_s &  owner_r & mst_r_valid;

    assign slv0_b_chan   = mst_b_chan;
    assign slv1_b_chan   = mst_b_chan;
    assign mst_b_ready   = st_b_s & (owner_r ? slv1_b_ready : slv0_b_ready);
    assign slv0_b_valid  = st_b_s & ~owner_r & mst_b_valid;
    assign slv1_b_valid  = st_b_s &  owner_r & mst_b_valid;

endmodule

// File: tb/tb_hyperbus_axi_arbiter.sv
// Directed self-checking bench for hyperbus_axi_arbiter; the bench plays both
// masters and the downstream slave.
module tb_hyperbus_axi_arbiter;

    localparam int AX_W = 113;
    localparam int W_W  = 83;
    localparam int R_W  = 87;
    localparam int B_W  = 22;

    logic clk, rst_i;
    logic [AX_W-1:0] slv0_ar_chan, slv0_aw_chan, slv1_ar_chan, slv1_aw_chan, mst_ar_chan, mst_aw_chan;
    logic [W_W-1:0]  slv0_w_chan, slv1_w_chan, mst_w_chan;
    logic [R_W-1:0]  slv0_r_chan, slv1_r_chan, mst_r_chan;
    logic [B_W-1:0]  slv0_b_chan, slv1_b_chan, mst_b_chan;
    logic slv0_ar_valid, slv0_ar_ready, slv0_aw_valid, slv0_aw_ready, slv0_w_valid, slv0_w_ready;
    logic slv0_r_valid, slv0_r_ready, slv0_b_valid, slv0_b_ready;
    logic slv1_ar_valid, slv1_ar_ready, slv1_aw_valid, slv1_aw_ready, slv1_w_valid, slv1_w_ready;
    logic slv1_r_valid, slv1_r_ready, slv1_b_valid, slv1_b_ready;
    logic mst_ar_valid, mst_ar_ready, mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready;
    logic mst_r_valid, mst_r_ready, mst_b_valid, mst_b_ready;

    logic [9:0]  src_id   [4];
    logic [63:0] src_addr [4];
    logic [7:0]  src_len  [4];

    int n_checks = 0;
    int n_fail   = 0;

    hyperbus_axi_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv0_ar_chan(slv0_ar_chan), .slv0_ar_valid(slv0_ar_valid), .slv0_ar_ready(slv0_ar_ready),
        .slv0_aw_chan(slv0_aw_chan), .slv0_aw_valid(slv0_aw_valid), .slv0_aw_ready(slv0_aw_ready),
        .slv0_w_chan(slv0_w_chan), .slv0_w_valid(slv0_w_valid), .slv0_w_ready(slv0_w_ready),
        .slv0_r_chan(slv0_r_chan), .slv0_r_valid(slv0_r_valid), .slv0_r_ready(slv0_r_ready),
        .slv0_b_chan(slv0_b_chan), .slv0_b_valid(slv0_b_valid), .slv0_b_ready(slv0_b_ready),
        .slv1_ar_chan(slv1_ar_chan), .slv1_ar_valid(slv1_ar_valid), .slv1_ar_ready(slv1_ar_ready),
        .slv1_aw_chan(slv1_aw_chan), .slv1_aw_valid(slv1_aw_valid), .slv1_aw_ready(slv1_aw_ready),
        .slv1_w_chan(slv1_w_chan), .slv1_w_valid(slv1_w_valid), .slv1_w_ready(slv1_w_ready),
        .slv1_r_chan(slv1_r_chan), .slv1_r_valid(slv1_r_valid), .slv1_r_ready(slv1_r_ready),
        .slv1_b_chan(slv1_b_chan), .slv1_b_valid(slv1_b_valid), .slv1_b_ready(slv1_b_ready),
        .mst_ar_chan(mst_ar_chan), .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_aw_chan(mst_aw_chan), .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_chan(mst_w_chan), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_r_chan(mst_r_chan), .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready),
        .mst_b_chan(mst_b_chan), .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] hs_outs();
        return {mst_ar_valid, mst_aw_valid, mst_w_valid, mst_r_ready, mst_b_ready,
                slv0_ar_ready, slv0_aw_ready, slv0_w_ready, slv0_r_valid, slv0_b_valid,
                slv1_ar_ready, slv1_aw_ready, slv1_w_ready, slv1_r_valid, slv1_b_valid};
    endfunction

    function automatic logic [AX_W-1:0] ax_pack(input int s);
        return {src_id[s], src_addr[s], src_len[s], 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 10'(s)};
    endfunction

    function automatic logic [W_W-1:0] w_pack(input int s, input int b, input logic last);
        return {src_addr[s][31:0], 32'(b), 8'hff, 10'h000, last};
    endfunction

    function automatic logic [R_W-1:0] r_pack(input int s, input int b, input logic last);
        return {src_id[s], src_addr[s][31:0], 32'(b), 2'b00, 10'h000, last};
    endfunction

    task automatic drive_req(input int s);
        case (s)
            0: begin slv0_ar_valid = 1'b1; slv0_ar_chan = ax_pack(0); end
            1: begin slv0_aw_valid = 1'b1; slv0_aw_chan = ax_pack(1); end
            2: begin slv1_ar_valid = 1'b1; slv1_ar_chan = ax_pack(2); end
            default: begin slv1_aw_valid = 1'b1; slv1_aw_chan = ax_pack(3); end
        endcase
    endtask

    task automatic clear_req(input int s);
        case (s)
            0: slv0_ar_valid = 1'b0;
            1: slv0_aw_valid = 1'b0;
            2: slv1_ar_valid = 1'b0;
            default: slv1_aw_valid = 1'b0;
        endcase
    endtask

    task automatic set_w(input logic port, input logic v, input logic [W_W-1:0] chan);
        if (port) begin slv1_w_valid = v; slv1_w_chan = chan; end
        else begin slv0_w_valid = v; slv0_w_chan = chan; end
    endtask

    task automatic clear_all();
        {slv0_ar_valid, slv0_aw_valid, slv0_w_valid, slv1_ar_valid, slv1_aw_valid, slv1_w_valid} = 6'b0;
        {mst_ar_ready, mst_aw_ready, mst_w_ready, mst_r_valid, mst_b_valid} = 5'b0;
        {slv0_r_ready, slv0_b_ready, slv1_r_ready, slv1_b_ready} = 4'b1111;
        slv0_ar_chan = '0; slv0_aw_chan = '0; slv1_ar_chan = '0; slv1_aw_chan = '0;
        slv0_w_chan = '0; slv1_w_chan = '0; mst_r_chan = '0; mst_b_chan = '0;
    endtask

    // Waits for the grant of source s and completes its whole transaction as the downstream slave.
    task automatic serve_one(input int s, input bit bp, output int waited);
        logic       port, is_wr;
        logic [1:0] one;
        int         nb, dly;
        port   = s[1];
        is_wr  = s[0];
        one    = port ? 2'b10 : 2'b01;
        nb     = int'(src_len[s]) + 1;
        waited = 0;
        @(negedge clk);
        while (!(mst_ar_valid || mst_aw_valid) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check_val("grant_timeout", 128'(waited), 128'd0);
            clear_req(s);
            @(posedge clk); #1;
            return;
        end
        check_val("grant_dir", {mst_aw_valid, mst_ar_valid}, is_wr ? 2'b10 : 2'b01);
        check_val("grant_chan", is_wr ? mst_aw_chan : mst_ar_chan, ax_pack(s));
        dly = bp ? int'($urandom_range(3, 0)) : 0;
        repeat (dly) @(negedge clk);
        if (is_wr) mst_aw_ready = 1'b1;
        else       mst_ar_ready = 1'b1;
        #1;
        check_val("ax_ready_route",
                  {slv1_aw_ready, slv0_aw_ready, slv1_ar_ready, slv0_ar_ready, slv1_w_ready, slv0_w_ready, mst_w_valid},
                  is_wr ? {one, 2'b00, 3'b000} : {2'b00, one, 3'b000});
        @(posedge clk); #1;
        mst_ar_ready = 1'b0;
        mst_aw_ready = 1'b0;
        clear_req(s);
        if (!is_wr) begin
            for (int b = 0; b < nb; b++) begin
                mst_r_valid = 1'b1;
                mst_r_chan  = r_pack(s, b, b == nb - 1);
                if (bp && b == 1) begin
                    if (port) slv1_r_ready = 1'b0; else slv0_r_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check_val("r_stall", {slv1_r_valid, slv0_r_valid, mst_r_ready}, {one, 1'b0});
                        @(posedge clk); #1;
                    end
                    slv0_r_ready = 1'b1;
                    slv1_r_ready = 1'b1;
                end
                @(negedge clk);
                check_val("r_route", {slv1_r_valid, slv0_r_valid, mst_r_ready}, {one, 1'b1});
                check_val("r_data", port ? slv1_r_chan : slv0_r_chan, r_pack(s, b, b == nb - 1));
                @(posedge clk); #1;
            end
            mst_r_valid = 1'b0;
        end else begin
            mst_w_ready = 1'b1;
            for (int b = 0; b < nb; b++) begin
                set_w(port, 1'b1, w_pack(s, b, b == nb - 1));
                @(negedge clk);
                check_val("w_route", {mst_w_valid, slv1_w_ready, slv0_w_ready}, {1'b1, one});
                check_val("w_data", mst_w_chan, w_pack(s, b, b == nb - 1));
                @(posedge clk); #1;
            end
            set_w(port, 1'b0, '0);
            mst_w_ready = 1'b0;
            mst_b_valid = 1'b1;
            mst_b_chan  = {src_id[s], 2'b00, 10'h000};
            @(negedge clk);
            check_val("b_route", {slv1_b_valid, slv0_b_valid, mst_b_ready, mst_w_valid}, {one, 2'b10});
            check_val("b_id", port ? slv1_b_chan : slv0_b_chan, {src_id[s], 2'b00, 10'h000});
            @(posedge clk); #1;
            mst_b_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int exp_src;
        src_id[0] = 10'h005; src_addr[0] = 64'h1000; src_len[0] = 8'd3;
        src_id[1] = 10'h011; src_addr[1] = 64'h2000; src_len[1] = 8'd1;
        src_id[2] = 10'h012; src_addr[2] = 64'h3000; src_len[2] = 8'd3;
        src_id[3] = 10'h013; src_addr[3] = 64'h4000; src_len[3] = 8'd1;
        clear_all();
        rst_i = 1'b1;
        slv0_ar_valid = 1'b1;
        mst_ar_ready  = 1'b1;
        mst_r_valid   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", hs_outs(), 15'd0);
        clear_all();
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Single read from s0: one IDLE cycle before mst AR appears.
        drive_req(0);
        @(negedge clk);
        check_val("arb_latency", hs_outs(), 15'd0);
        @(posedge clk); #1;
        serve_one(0, 1'b0, waited);
        check_val("ar_first_cycle", 128'(waited), 128'd0);
        @(negedge clk);
        check_val("idle_after_read", hs_outs(), 15'd0);
        @(posedge clk); #1;

        // Reset during beat 2 of a 4-beat read.
        drive_req(0);
        waited = 0;
        @(negedge clk);
        while (!mst_ar_valid && waited < 20) begin @(negedge clk); waited++; end
        check_val("t1_grant", mst_ar_valid, 1'b1);
        mst_ar_ready = 1'b1;
        @(posedge clk); #1;
        mst_ar_ready = 1'b0;
        clear_req(0);
        for (int b = 0; b < 2; b++) begin
            mst_r_valid = 1'b1;
            mst_r_chan  = r_pack(0, b, 1'b0);
            @(posedge clk); #1;
        end
        mst_r_valid = 1'b1;
        mst_r_chan  = r_pack(0, 2, 1'b0);
        @(negedge clk);
        check_val("t1_beat2_live", {slv0_r_valid, mst_r_ready}, 2'b11);
        rst_i = 1'b1;
        #1;
        check_val("t1_rst_async", hs_outs(), 15'd0);
        @(posedge clk); #1;
        clear_all();
        rst_i = 1'b0;
        @(negedge clk);
        check_val("t1_after_rst", hs_outs(), 15'd0);
        @(posedge clk); #1;

        // Contention at ptr=0: s0.ar, s1.ar, s1.aw; then ptr has wrapped to 0.
        drive_req(0); drive_req(2); drive_req(3);
        serve_one(0, 1'b0, waited);
        serve_one(2, 1'b0, waited);
        serve_one(3, 1'b0, waited);
        drive_req(0); drive_req(3);
        serve_one(0, 1'b0, waited);
        serve_one(3, 1'b0, waited);

        // Early W from s1 is stalled until the AW handshake.
        mst_w_ready = 1'b1;
        set_w(1'b1, 1'b1, w_pack(3, 0, 1'b0));
        repeat (2) begin
            @(negedge clk);
            check_val("early_w_stall", {slv1_w_ready, mst_w_valid}, 2'b00);
            @(posedge clk); #1;
        end
        drive_req(3);
        serve_one(3, 1'b0, waited);

        // Backpressure on a 4-beat s1 read.
        drive_req(2);
        serve_one(2, 1'b1, waited);

        // All four sources continuously requesting: strict rotation from ptr=3.
        exp_src = 3;
        for (int k = 0; k < 40; k++) begin
            for (int s = 0; s < 4; s++) drive_req(s);
            serve_one(exp_src, k[0], waited);
            check_val("fair_wait", 128'(waited <= 3), 128'd1);
            exp_src = (exp_src + 1) % 4;
        end
        for (int s = 0; s < 4; s++) clear_req(s);
        @(negedge clk);
        check_val("final_idle", hs_outs(), 15'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
